// File: rtl/memoredf_pkg.sv
// Shared types and default sizing for the MemGuard dispatch path.
// Optional statistics are enabled with the QUEUE_DISPATCHER_STATS_EN macro.
package memoredf_pkg;
  localparam int NUM_QUEUES_DEFAULT      = 4;
  localparam int DATA_WIDTH_DEFAULT      = 64;
  localparam int MAX_OUTSTANDING_DEFAULT = 4;
  localparam int QUEUE_ID_WIDTH          = $clog2(NUM_QUEUES_DEFAULT);

  typedef enum logic {IDLE, SEND} dispatch_state_t;

  typedef logic [DATA_WIDTH_DEFAULT-1:0] descriptor_t;
endpackage

// File: rtl/queue_dispatcher_if.sv
// Grant, queue, memory-side and completion signals of queue_dispatcher.
// issued_count exists only when QUEUE_DISPATCHER_STATS_EN is defined.
interface queue_dispatcher_if
  import memoredf_pkg::*;
#(
  parameter int NUMBER_OF_QUEUES = NUM_QUEUES_DEFAULT,
  parameter int DATA_WIDTH       = DATA_WIDTH_DEFAULT
);
  localparam int QID_W = (NUMBER_OF_QUEUES > 1) ? $clog2(NUMBER_OF_QUEUES) : 1;

  logic                                        valid;
  logic [QID_W-1:0]                            selection;
  logic [NUMBER_OF_QUEUES-1:0]                 empty;
  logic [NUMBER_OF_QUEUES-1:0][DATA_WIDTH-1:0] head_data;
  logic [NUMBER_OF_QUEUES-1:0]                 pop;
  logic [NUMBER_OF_QUEUES-1:0]                 consumed;
  logic                                        m_valid;
  logic                                        m_ready;
  logic [DATA_WIDTH-1:0]                       m_data;
  logic [QID_W-1:0]                            m_qid;
  logic                                        resp_valid;
  logic [7:0]                                  outstanding;
  logic                                        error;
`ifdef QUEUE_DISPATCHER_STATS_EN
  logic [NUMBER_OF_QUEUES-1:0][31:0]           issued_count;
`endif

  modport master (
    input  valid, selection, empty, head_data, m_ready, resp_valid,
    output pop, consumed, m_valid, m_data, m_qid, outstanding, error
`ifdef QUEUE_DISPATCHER_STATS_EN
    , output issued_count
`endif
  );

  modport slave (
    output valid, selection, empty, head_data, m_ready, resp_valid,
    input  pop, consumed, m_valid, m_data, m_qid, outstanding, error
`ifdef QUEUE_DISPATCHER_STATS_EN
    , input issued_count
`endif
  );
endinterface

// File: rtl/queue_dispatcher_outstanding_counter.sv
// In-flight transaction counter: up on issue, down on completion, floors at zero.
// A completion with nothing in flight sets a sticky error flag.
module outstanding_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  input  logic [7:0] max,
  output logic [7:0] count,
  output logic       error
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= 8'd0;
      error <= 1'b0;
    end else begin
      if (dec && (count == 8'd0)) error <= 1'b1;
      unique case ({inc, dec})
        2'b10:   if (count < max) count <= count + 8'd1;
        2'b01:   if (count != 8'd0) count <= count - 8'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/queue_dispatcher.sv
// Pops the MemGuard-granted queue and forwards its head descriptor downstream.
// Optional per-queue issue counters: define QUEUE_DISPATCHER_STATS_EN.
module queue_dispatcher
  import memoredf_pkg::*;
#(
  parameter int NUMBER_OF_QUEUES = NUM_QUEUES_DEFAULT,
  parameter int DATA_WIDTH       = DATA_WIDTH_DEFAULT,
  parameter int MAX_OUTSTANDING  = MAX_OUTSTANDING_DEFAULT
) (
  input logic               clock,
  input logic               reset,
  queue_dispatcher_if.master bus
);
  localparam int QID_W = (NUMBER_OF_QUEUES > 1) ? $clog2(NUMBER_OF_QUEUES) : 1;

  dispatch_state_t             state, next_state;
  logic                        accept;
  logic                        handshake;
  logic [NUMBER_OF_QUEUES-1:0] grant_one_hot;
  logic [7:0]                  count;
  logic                        count_error;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    accept        = 1'b0;
    handshake     = 1'b0;
    grant_one_hot = '0;
    grant_one_hot[bus.selection] = 1'b1;
    unique case (state)
      IDLE: begin
        if (bus.valid && !bus.empty[bus.selection] &&
            (count < 8'(MAX_OUTSTANDING)) &&
            (32'(bus.selection) < NUMBER_OF_QUEUES)) begin
          accept     = 1'b1;
          next_state = SEND;
        end
      end
      SEND: begin
        if (bus.m_ready) begin
          handshake  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Descriptor is captured on the accept edge and held through the whole SEND phase.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.pop      <= '0;
      bus.consumed <= '0;
      bus.m_data   <= '0;
      bus.m_qid    <= '0;
    end else begin
      bus.pop      <= accept ? grant_one_hot : '0;
      bus.consumed <= accept ? grant_one_hot : '0;
      if (accept) begin
        bus.m_data <= bus.head_data[bus.selection];
        bus.m_qid  <= bus.selection;
      end
    end
  end

  assign bus.m_valid = (state == SEND);

  outstanding_counter u_outstanding (
    .clock (clock),
    .reset (reset),
    .inc   (handshake),
    .dec   (bus.resp_valid),
    .max   (8'(MAX_OUTSTANDING)),
    .count (count),
    .error (count_error)
  );

  assign bus.outstanding = count;
  assign bus.error       = count_error;

`ifdef QUEUE_DISPATCHER_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.issued_count <= '0;
    end else if (handshake) begin
      bus.issued_count[bus.m_qid] <= bus.issued_count[bus.m_qid] + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_queue_dispatcher.sv
// Directed bench for queue_dispatcher with 4 queues, 64-bit descriptors, limit 4.
module tb_queue_dispatcher;
  import memoredf_pkg::*;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  queue_dispatcher_if #(.NUMBER_OF_QUEUES(4), .DATA_WIDTH(64)) bus ();

  queue_dispatcher #(
    .NUMBER_OF_QUEUES(4),
    .DATA_WIDTH(64),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    total++; if (bus.pop !== 4'b0000) begin bad++; $display("FAIL reset_pop got=%b want=0000", bus.pop); end
    total++; if (bus.consumed !== 4'b0000) begin bad++; $display("FAIL reset_consumed got=%b want=0000", bus.consumed); end
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", bus.m_valid); end
    total++; if (bus.m_data !== 64'h0) begin bad++; $display("FAIL reset_m_data got=%h want=0", bus.m_data); end
    total++; if (bus.m_qid !== 2'd0) begin bad++; $display("FAIL reset_m_qid got=%0d want=0", bus.m_qid); end
    total++; if (bus.outstanding !== 8'd0) begin bad++; $display("FAIL reset_outstanding got=%0d want=0", bus.outstanding); end
    total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", bus.error); end
    reset = 1'b0;
  endtask

  task automatic test_single_grant();
    descriptor_t d;
    d = 64'hA5;
    bus.empty        = 4'b1011;
    bus.head_data[0] = 64'h1000;
    bus.head_data[1] = 64'h2000;
    bus.head_data[2] = d;
    bus.head_data[3] = 64'h4000;
    bus.selection    = 2'd2;
    bus.m_ready      = 1'b1;
    bus.valid        = 1'b1;
    tick();  // accept edge
    bus.valid = 1'b0;
    total++; if (bus.pop !== 4'b0100) begin bad++; $display("FAIL single_pop got=%b want=0100", bus.pop); end
    total++; if (bus.consumed !== 4'b0100) begin bad++; $display("FAIL single_consumed got=%b want=0100", bus.consumed); end
    total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL single_m_valid got=%b want=1", bus.m_valid); end
    total++; if (bus.m_data !== 64'hA5) begin bad++; $display("FAIL single_m_data got=%h want=a5", bus.m_data); end
    total++; if (bus.m_qid !== 2'd2) begin bad++; $display("FAIL single_m_qid got=%0d want=2", bus.m_qid); end
    total++; if (bus.outstanding !== 8'd0) begin bad++; $display("FAIL single_out_pre got=%0d want=0", bus.outstanding); end
    tick();  // handshake edge
    total++; if (bus.pop !== 4'b0000) begin bad++; $display("FAIL single_pop_one_cycle got=%b want=0000", bus.pop); end
    total++; if (bus.consumed !== 4'b0000) begin bad++; $display("FAIL single_consumed_one_cycle got=%b want=0000", bus.consumed); end
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL single_m_valid_drop got=%b want=0", bus.m_valid); end
    total++; if (bus.outstanding !== 8'd1) begin bad++; $display("FAIL single_outstanding got=%0d want=1", bus.outstanding); end
  endtask

  task automatic test_backpressure();
    bus.empty        = 4'b0000;
    bus.head_data[1] = 64'hDEAD_BEEF_0000_1111;
    bus.selection    = 2'd1;
    bus.m_ready      = 1'b0;
    bus.valid        = 1'b1;
    tick();
    total++; if (bus.pop !== 4'b0010) begin bad++; $display("FAIL bp_pop got=%b want=0010", bus.pop); end
    total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL bp_m_valid got=%b want=1", bus.m_valid); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d] got=%b want=1", i, bus.m_valid); end
      total++; if (bus.m_data !== 64'hDEAD_BEEF_0000_1111) begin bad++; $display("FAIL bp_hold_data[%0d] got=%h want=deadbeef00001111", i, bus.m_data); end
      total++; if (bus.m_qid !== 2'd1) begin bad++; $display("FAIL bp_hold_qid[%0d] got=%0d want=1", i, bus.m_qid); end
      total++; if (bus.pop !== 4'b0000) begin bad++; $display("FAIL bp_no_pop[%0d] got=%b want=0000", i, bus.pop); end
      total++; if (bus.consumed !== 4'b0000) begin bad++; $display("FAIL bp_no_consumed[%0d] got=%b want=0000", i, bus.consumed); end
    end
    bus.valid   = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", bus.m_valid); end
    total++; if (bus.outstanding !== 8'd2) begin bad++; $display("FAIL bp_outstanding got=%0d want=2", bus.outstanding); end
    tick();
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL bp_idle got=%b want=0", bus.m_valid); end
    bus.resp_valid = 1'b1;
    repeat (2) tick();
    bus.resp_valid = 1'b0;
    total++; if (bus.outstanding !== 8'd0) begin bad++; $display("FAIL bp_drain got=%0d want=0", bus.outstanding); end
    total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL bp_error got=%b want=0", bus.error); end
  endtask

  task automatic test_empty_guard();
    bus.empty     = 4'b0001;
    bus.selection = 2'd0;
    bus.valid     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.pop !== 4'b0000) begin bad++; $display("FAIL empty_pop[%0d] got=%b want=0000", i, bus.pop); end
      total++; if (bus.consumed !== 4'b0000) begin bad++; $display("FAIL empty_consumed[%0d] got=%b want=0000", i, bus.consumed); end
      total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL empty_m_valid[%0d] got=%b want=0", i, bus.m_valid); end
    end
    bus.valid = 1'b0;
    bus.empty = 4'b0000;
  endtask

  task automatic test_outstanding_limit();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.selection = 2'(i);
      bus.valid     = 1'b1;
      tick();
      bus.valid = 1'b0;
      tick();
    end
    total++; if (bus.outstanding !== 8'd4) begin bad++; $display("FAIL limit_full got=%0d want=4", bus.outstanding); end
    bus.selection = 2'd3;
    bus.valid     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.pop !== 4'b0000) begin bad++; $display("FAIL limit_blocked_pop[%0d] got=%b want=0000", i, bus.pop); end
      total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL limit_blocked_valid[%0d] got=%b want=0", i, bus.m_valid); end
    end
    bus.resp_valid = 1'b1;
    tick();
    bus.resp_valid = 1'b0;
    total++; if (bus.outstanding !== 8'd3) begin bad++; $display("FAIL limit_after_resp got=%0d want=3", bus.outstanding); end
    total++; if (bus.pop !== 4'b0000) begin bad++; $display("FAIL limit_resp_edge_pop got=%b want=0000", bus.pop); end
    tick();
    bus.valid = 1'b0;
    total++; if (bus.pop !== 4'b1000) begin bad++; $display("FAIL limit_reaccept_pop got=%b want=1000", bus.pop); end
    total++; if (bus.m_qid !== 2'd3) begin bad++; $display("FAIL limit_reaccept_qid got=%0d want=3", bus.m_qid); end
    tick();
    total++; if (bus.outstanding !== 8'd4) begin bad++; $display("FAIL limit_refill got=%0d want=4", bus.outstanding); end
  endtask

  task automatic test_simultaneous();
    bus.resp_valid = 1'b1;
    tick();
    bus.resp_valid = 1'b0;
    total++; if (bus.outstanding !== 8'd3) begin bad++; $display("FAIL simul_pre got=%0d want=3", bus.outstanding); end
    bus.selection = 2'd0;
    bus.valid     = 1'b1;
    bus.m_ready   = 1'b1;
    tick();
    bus.valid      = 1'b0;
    bus.resp_valid = 1'b1;
    tick();
    bus.resp_valid = 1'b0;
    total++; if (bus.outstanding !== 8'd3) begin bad++; $display("FAIL simul_unchanged got=%0d want=3", bus.outstanding); end
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL simul_m_valid got=%b want=0", bus.m_valid); end
    bus.resp_valid = 1'b1;
    repeat (3) tick();
    bus.resp_valid = 1'b0;
    total++; if (bus.outstanding !== 8'd0) begin bad++; $display("FAIL simul_drain got=%0d want=0", bus.outstanding); end
    total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL simul_no_error got=%b want=0", bus.error); end
    bus.resp_valid = 1'b1;
    tick();
    bus.resp_valid = 1'b0;
    total++; if (bus.error !== 1'b1) begin bad++; $display("FAIL underflow_error got=%b want=1", bus.error); end
    total++; if (bus.outstanding !== 8'd0) begin bad++; $display("FAIL underflow_count got=%0d want=0", bus.outstanding); end
    repeat (3) tick();
    total++; if (bus.error !== 1'b1) begin bad++; $display("FAIL error_sticky got=%b want=1", bus.error); end
  endtask

  task automatic test_async_reset_mid_send();
    bus.selection    = 2'd2;
    bus.head_data[2] = 64'h0123_4567_89AB_CDEF;
    bus.m_ready      = 1'b1;
    bus.valid        = 1'b1;
    tick();
    bus.valid = 1'b0;
    tick();
    bus.m_ready = 1'b0;
    bus.valid   = 1'b1;
    tick();
    bus.valid = 1'b0;
    total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL arst_setup_valid got=%b want=1", bus.m_valid); end
    total++; if (bus.outstanding !== 8'd1) begin bad++; $display("FAIL arst_setup_out got=%0d want=1", bus.outstanding); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL arst_m_valid got=%b want=0", bus.m_valid); end
    total++; if (bus.outstanding !== 8'd0) begin bad++; $display("FAIL arst_outstanding got=%0d want=0", bus.outstanding); end
    total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL arst_error got=%b want=0", bus.error); end
    total++; if (bus.pop !== 4'b0000) begin bad++; $display("FAIL arst_pop got=%b want=0000", bus.pop); end
    total++; if (bus.m_data !== 64'h0) begin bad++; $display("FAIL arst_m_data got=%h want=0", bus.m_data); end
    @(negedge clock);
    reset = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL arst_idle_after got=%b want=0", bus.m_valid); end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset          = 1'b1;
    bus.valid      = 1'b0;
    bus.selection  = '0;
    bus.empty      = 4'b1111;
    bus.head_data  = '0;
    bus.m_ready    = 1'b0;
    bus.resp_valid = 1'b0;
    test_reset();
    test_single_grant();
    test_backpressure();
    test_empty_guard();
    test_outstanding_limit();
    test_simultaneous();
    test_async_reset_mid_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/queue_dispatcher.md
Name: queue_dispatcher

Overview:
- Sits directly downstream of MemGuard.
- Consumes MemGuard's valid/selection grant, pops the granted per-core request queue and forwards the head descriptor to the memory-side port over a valid/ready handshake.
- Returns a one-hot consumed pulse to MemGuard so budgets are charged per issued transaction.
- Caps in-flight transactions using completion responses.

Parameters:
- NUMBER_OF_QUEUES, 4, number of request queues; must match MemGuard.
- DATA_WIDTH, 64, width of a request descriptor.
- MAX_OUTSTANDING, 4, maximum issued-but-uncompleted transactions, range 1..255.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid  in  1  MemGuard grant valid.
- selection  in  $clog2(NUMBER_OF_QUEUES)  granted queue index.
- empty  in  NUMBER_OF_QUEUES  per-queue empty flags.
- head_data  in  NUMBER_OF_QUEUES x DATA_WIDTH  per-queue head descriptor.
- pop  out  NUMBER_OF_QUEUES  one-hot dequeue strobe to the queues.
- consumed  out  NUMBER_OF_QUEUES  one-hot charge pulse to MemGuard.
- m_valid  out  1  downstream request valid.
- m_ready  in  1  downstream request ready.
- m_data  out  DATA_WIDTH  downstream descriptor.
- m_qid  out  $clog2(NUMBER_OF_QUEUES)  originating queue of m_data.
- resp_valid  in  1  one-cycle pulse: one transaction completed.
- outstanding  out  8  current in-flight count.
- error  out  1  sticky: resp_valid seen with outstanding==0.

Behaviour:
- Reset (async, immediate): state=IDLE; pop, consumed, m_valid, error = 0; m_data, m_qid, outstanding = 0. Reset mid-SEND drops m_valid without completing the handshake; the descriptor is lost. Upstream queues are reset by the same signal.
- FSM states: IDLE, SEND.
- IDLE accept condition, sampled at a rising edge: valid=1 AND empty[selection]=0 AND outstanding<MAX_OUTSTANDING AND selection<NUMBER_OF_QUEUES.
- On accept:
  - Register m_data=head_data[selection] and m_qid=selection.
  - Next state SEND.
  - pop[selection] and consumed[selection] are high for exactly the one cycle following the accept edge. Both are registered, one-hot and identical.
- IDLE with the accept condition false: stay in IDLE; pop and consumed stay 0. A grant for an empty queue is ignored, not charged.
- SEND:
  - m_valid=1; m_data and m_qid are held stable until the handshake.
  - At an edge with m_ready=1: handshake completes; next state IDLE; m_valid=0 in the following cycle.
  - m_ready=0: stay in SEND indefinitely.
  - Grants arriving during SEND are ignored.
- Latency: accept edge to m_valid high is 1 cycle. Peak throughput is 1 transaction per 2 cycles (with m_ready held high).
- outstanding counter:
  - Handshake edge alone: +1.
  - resp_valid edge alone: -1.
  - Both on the same edge: unchanged.
  - resp_valid with outstanding==0: counter stays 0 and error is set; error clears only on reset.
  - Counter never exceeds MAX_OUTSTANDING; it is checked at accept, so at most one SEND is pending.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: QUEUE_DISPATCHER_STATS_EN.
- Defined: adds output issued_count (NUMBER_OF_QUEUES x 32).
  - Per-queue counter incremented on each completed m_valid/m_ready handshake for m_qid.
  - Wraps at 2^32; cleared by reset.
- Undefined: port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package memoredf_pkg:
  - QUEUE_ID_WIDTH constant: $clog2(NUMBER_OF_QUEUES).
  - dispatch_state_t enum {IDLE, SEND}.
  - Descriptor typedef of DATA_WIDTH bits.
- One natural sub-module: outstanding_counter. It holds the up/down saturating-at-zero counter and the error flag, with inputs inc, dec and max.

Test Plan:
- Reset then single grant: valid=1, selection=2, empty=4'b1011, head_data[2]=64'hA5, m_ready=1.
  - Required: pop=consumed=4'b0100 for one cycle; m_valid one cycle later with m_data=64'hA5, m_qid=2; outstanding=1.
- Backpressure: m_ready=0 for 5 cycles in SEND.
  - Required: m_valid, m_data and m_qid stable for 5 cycles; no further pop while valid=1, selection=1.
  - Raising m_ready completes the handshake and returns the FSM to IDLE.
- Empty guard: valid=1, selection=0, empty=4'b0001.
  - Required: no pop, no consumed, m_valid stays 0.
- Outstanding limit, MAX_OUTSTANDING=4: 4 handshakes with no resp_valid.
  - Required: a 5th grant is ignored.
  - One resp_valid pulse lets the next grant be accepted; outstanding goes 4 -> 3 -> 4.
- Simultaneous events: handshake and resp_valid on the same edge leave outstanding unchanged.
  - resp_valid at outstanding=0 sets error=1 and holds it until reset.
  - Async reset asserted mid-SEND clears m_valid and outstanding without waiting for a clock edge.
